// File: rtl/data_memory_pkg.sv
// Shared types and default sizing for the data cache way arrays.
package data_memory_pkg;

  localparam int DEF_SETS       = 64;
  localparam int DEF_LINE_WORDS = 4;
  localparam int DEF_WORD_WIDTH = 32;
  localparam int DEF_TAG_WIDTH  = 20;

  // Per-field enables for port 0 accesses: {valid, dirty, tag, data}.
  typedef struct packed {
    logic valid;
    logic dirty;
    logic tag;
    logic data;
  } data_cache_enable_t;

  // Invalidation sweep state.
  typedef enum logic {
    SWEEP_IDLE = 1'b0,
    SWEEP_RUN  = 1'b1
  } data_way_sweep_t;

  // Word-select width; a one-word line still carries a 1-bit select.
  function automatic int sel_width(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/data_cache_way_array_if.sv
// Access bus of one cache way: port 0 (store/refill, read/write) and
// port 1 (load, read-only). The cache top drives the master side.
interface data_cache_way_array_if #(
  parameter int SETS       = data_memory_pkg::DEF_SETS,
  parameter int LINE_WORDS = data_memory_pkg::DEF_LINE_WORDS,
  parameter int WORD_WIDTH = data_memory_pkg::DEF_WORD_WIDTH,
  parameter int TAG_WIDTH  = data_memory_pkg::DEF_TAG_WIDTH
);
  import data_memory_pkg::*;

  localparam int IDX_W = $clog2(SETS);
  localparam int SEL_W = sel_width(LINE_WORDS);
  localparam int BYTES = WORD_WIDTH / 8;

  data_cache_enable_t    port0_enable_i;
  logic [IDX_W-1:0]      port0_index_i;
  logic [SEL_W-1:0]      port0_word_sel_i;
  logic [BYTES-1:0]      port0_byte_write_i;
  logic                  port0_valid_i;
  logic                  port0_dirty_i;
  logic [TAG_WIDTH-1:0]  port0_tag_i;
  logic [WORD_WIDTH-1:0] port0_word_i;
  logic                  port0_write_i;
  logic                  port0_read_i;
  logic                  port0_valid_o;
  logic                  port0_dirty_o;
  logic [TAG_WIDTH-1:0]  port0_tag_o;

  logic [IDX_W-1:0]      port1_index_i;
  logic [SEL_W-1:0]      port1_word_sel_i;
  logic                  port1_read_i;
  logic                  port1_valid_o;
  logic                  port1_dirty_o;
  logic [TAG_WIDTH-1:0]  port1_tag_o;
  logic [WORD_WIDTH-1:0] port1_word_o;

  modport master (
    output port0_enable_i, port0_index_i, port0_word_sel_i, port0_byte_write_i,
           port0_valid_i, port0_dirty_i, port0_tag_i, port0_word_i,
           port0_write_i, port0_read_i,
           port1_index_i, port1_word_sel_i, port1_read_i,
    input  port0_valid_o, port0_dirty_o, port0_tag_o,
           port1_valid_o, port1_dirty_o, port1_tag_o, port1_word_o
  );

  modport slave (
    input  port0_enable_i, port0_index_i, port0_word_sel_i, port0_byte_write_i,
           port0_valid_i, port0_dirty_i, port0_tag_i, port0_word_i,
           port0_write_i, port0_read_i,
           port1_index_i, port1_word_sel_i, port1_read_i,
    output port0_valid_o, port0_dirty_o, port0_tag_o,
           port1_valid_o, port1_dirty_o, port1_tag_o, port1_word_o
  );

endinterface

// File: rtl/data_way_sweep_fsm.sv
// Invalidation sweep controller: walks every set once after reset and
// after each accepted flush, clearing valid/dirty one set per cycle.
//
// state      | meaning
// -----------+------------------------------------------------------
// SWEEP_IDLE | normal operation, accesses accepted, waits for flush
// SWEEP_RUN  | clearing set[cnt]; busy high; ends after set SETS-1
module data_way_sweep_fsm
  import data_memory_pkg::*;
#(
  parameter int SETS  = DEF_SETS,
  localparam int IDX_W = $clog2(SETS)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             clear_en_o,
  output logic [IDX_W-1:0] clear_idx_o
);

  data_way_sweep_t  state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             flush_q, flush_d;

  // State, counter and captured flush request; reset starts a sweep.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= SWEEP_RUN;
      cnt_q   <= '0;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      flush_q <= flush_d;
    end
  end

  // Next state; a flush is only captured while idle, so pulses seen
  // during a sweep never restart it.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    flush_d     = 1'b0;
    clear_en_o  = 1'b0;
    clear_idx_o = cnt_q;
    unique case (state_q)
      SWEEP_IDLE: begin
        flush_d = flush_i & ~flush_q;
        if (flush_q) begin
          state_d = SWEEP_RUN;
          cnt_d   = '0;
        end
      end
      SWEEP_RUN: begin
        clear_en_o = 1'b1;
        if (cnt_q == IDX_W'(SETS - 1)) begin
          state_d = SWEEP_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + IDX_W'(1);
        end
      end
      default: begin
        state_d = SWEEP_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  assign busy_o = (state_q == SWEEP_RUN);

endmodule

// File: rtl/data_cache_way_array.sv
// One data cache way: status (valid/dirty), tag and data storage with a
// read/write port 0 and a read-only port 1, plus the invalidation sweep.
// Build option: define DATA_CACHE_WAY_FORWARD_EN to forward a same-cycle
// port 0 write to a port 1 read of the same set.
module data_cache_way_array
  import data_memory_pkg::*;
#(
  parameter int SETS       = DEF_SETS,
  parameter int LINE_WORDS = DEF_LINE_WORDS,
  parameter int WORD_WIDTH = DEF_WORD_WIDTH,
  parameter int TAG_WIDTH  = DEF_TAG_WIDTH
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic enable_way_i,
  input  logic flush_i,
  output logic busy_o,
  data_cache_way_array_if.slave bus
);

  localparam int IDX_W = $clog2(SETS);
  localparam int SEL_W = sel_width(LINE_WORDS);
  localparam int BYTES = WORD_WIDTH / 8;

  logic             busy;
  logic             clear_en;
  logic [IDX_W-1:0] clear_idx;

  data_way_sweep_fsm #(.SETS(SETS)) u_sweep (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .flush_i     (flush_i),
    .busy_o      (busy),
    .clear_en_o  (clear_en),
    .clear_idx_o (clear_idx)
  );

  assign busy_o = busy;

  logic                  valid_mem [SETS];
  logic                  dirty_mem [SETS];
  logic [TAG_WIDTH-1:0]  tag_mem   [SETS];
  logic [WORD_WIDTH-1:0] data_mem  [SETS][LINE_WORDS];

  data_cache_enable_t en0;
  logic [IDX_W-1:0]   idx0, idx1;
  logic [SEL_W-1:0]   sel0, sel1;
  logic               wr_ok, valid_we, dirty_we, tag_we, data_we;

  // A one-word line has a single column regardless of the select value.
  assign sel0 = (LINE_WORDS > 1) ? bus.port0_word_sel_i : '0;
  assign sel1 = (LINE_WORDS > 1) ? bus.port1_word_sel_i : '0;
  assign idx0 = bus.port0_index_i;
  assign idx1 = bus.port1_index_i;
  assign en0  = bus.port0_enable_i;

  // Effective port 0 write strobes; all writes are dropped during a sweep.
  always_comb begin
    wr_ok    = bus.port0_write_i & enable_way_i & ~busy;
    valid_we = wr_ok & en0.valid;
    dirty_we = wr_ok & en0.dirty;
    tag_we   = wr_ok & en0.tag;
    data_we  = wr_ok & en0.data;
  end

  // Status array: the sweep clear and port writes never coincide.
  always_ff @(posedge clk_i) begin
    if (clear_en) begin
      valid_mem[clear_idx] <= 1'b0;
      dirty_mem[clear_idx] <= 1'b0;
    end else begin
      if (valid_we) valid_mem[idx0] <= bus.port0_valid_i;
      if (dirty_we) dirty_mem[idx0] <= bus.port0_dirty_i;
    end
  end

  // Tag and data arrays, data written byte-wise; the sweep leaves them alone.
  always_ff @(posedge clk_i) begin
    if (tag_we) tag_mem[idx0] <= bus.port0_tag_i;
    for (int b = 0; b < BYTES; b++) begin
      if (data_we && bus.port0_byte_write_i[b])
        data_mem[idx0][sel0][b*8 +: 8] <= bus.port0_word_i[b*8 +: 8];
    end
  end

  logic                  p1_valid_src, p1_dirty_src;
  logic [TAG_WIDTH-1:0]  p1_tag_src;
  logic [WORD_WIDTH-1:0] p1_word_src;

  // Port 1 source values: stored contents, optionally overridden by a
  // colliding port 0 write.
  always_comb begin
    p1_valid_src = valid_mem[idx1];
    p1_dirty_src = dirty_mem[idx1];
    p1_tag_src   = tag_mem[idx1];
    p1_word_src  = data_mem[idx1][sel1];
`ifdef DATA_CACHE_WAY_FORWARD_EN
    if (wr_ok && (idx1 == idx0)) begin
      if (en0.valid) p1_valid_src = bus.port0_valid_i;
      if (en0.dirty) p1_dirty_src = bus.port0_dirty_i;
      if (en0.tag)   p1_tag_src   = bus.port0_tag_i;
      if (en0.data && (sel1 == sel0)) begin
        for (int b = 0; b < BYTES; b++) begin
          if (bus.port0_byte_write_i[b])
            p1_word_src[b*8 +: 8] = bus.port0_word_i[b*8 +: 8];
        end
      end
    end
`endif
  end

  logic                  port0_valid_q, port0_valid_d;
  logic                  port0_dirty_q, port0_dirty_d;
  logic [TAG_WIDTH-1:0]  port0_tag_q, port0_tag_d;
  logic                  port1_valid_q, port1_valid_d;
  logic                  port1_dirty_q, port1_dirty_d;
  logic [TAG_WIDTH-1:0]  port1_tag_q, port1_tag_d;
  logic [WORD_WIDTH-1:0] port1_word_q, port1_word_d;

  // Read registers load only on a strobe; status reads as 0 mid-sweep.
  always_comb begin
    port0_valid_d = port0_valid_q;
    port0_dirty_d = port0_dirty_q;
    port0_tag_d   = port0_tag_q;
    port1_valid_d = port1_valid_q;
    port1_dirty_d = port1_dirty_q;
    port1_tag_d   = port1_tag_q;
    port1_word_d  = port1_word_q;
    if (bus.port0_read_i) begin
      if (en0.valid) port0_valid_d = valid_mem[idx0] & ~busy;
      if (en0.dirty) port0_dirty_d = dirty_mem[idx0] & ~busy;
      if (en0.tag)   port0_tag_d   = tag_mem[idx0];
    end
    if (bus.port1_read_i) begin
      port1_valid_d = p1_valid_src & ~busy;
      port1_dirty_d = p1_dirty_src & ~busy;
      port1_tag_d   = p1_tag_src;
      port1_word_d  = p1_word_src;
    end
  end

  // Read data registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      port0_valid_q <= 1'b0;
      port0_dirty_q <= 1'b0;
      port0_tag_q   <= '0;
      port1_valid_q <= 1'b0;
      port1_dirty_q <= 1'b0;
      port1_tag_q   <= '0;
      port1_word_q  <= '0;
    end else begin
      port0_valid_q <= port0_valid_d;
      port0_dirty_q <= port0_dirty_d;
      port0_tag_q   <= port0_tag_d;
      port1_valid_q <= port1_valid_d;
      port1_dirty_q <= port1_dirty_d;
      port1_tag_q   <= port1_tag_d;
      port1_word_q  <= port1_word_d;
    end
  end

  assign bus.port0_valid_o = port0_valid_q;
  assign bus.port0_dirty_o = port0_dirty_q;
  assign bus.port0_tag_o   = port0_tag_q;
  assign bus.port1_valid_o = port1_valid_q;
  assign bus.port1_dirty_o = port1_dirty_q;
  assign bus.port1_tag_o   = port1_tag_q;
  assign bus.port1_word_o  = port1_word_q;

endmodule

// File: tb/tb_data_cache_way_array.sv
// Directed bench for data_cache_way_array with default parameters.
module tb_data_cache_way_array;
  import data_memory_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable_way;
  logic flush;
  logic busy;
  int   checks = 0;
  int   errors = 0;
  int   n;

  data_cache_way_array_if #(.SETS(64), .LINE_WORDS(4), .WORD_WIDTH(32), .TAG_WIDTH(20)) bus ();

  data_cache_way_array #(.SETS(64), .LINE_WORDS(4), .WORD_WIDTH(32), .TAG_WIDTH(20)) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .enable_way_i (enable_way),
    .flush_i      (flush),
    .busy_o       (busy),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    enable_way                = 1'b1;
    flush                     = 1'b0;
    bus.port0_enable_i        = data_cache_enable_t'(4'b0000);
    bus.port0_index_i         = '0;
    bus.port0_word_sel_i      = '0;
    bus.port0_byte_write_i    = '0;
    bus.port0_valid_i         = 1'b0;
    bus.port0_dirty_i         = 1'b0;
    bus.port0_tag_i           = '0;
    bus.port0_word_i          = '0;
    bus.port0_write_i         = 1'b0;
    bus.port0_read_i          = 1'b0;
    bus.port1_index_i         = '0;
    bus.port1_word_sel_i      = '0;
    bus.port1_read_i          = 1'b0;
  endtask

  task automatic p0_write(input logic [5:0] idx, input logic [1:0] sel, input logic [3:0] en,
                          input logic [3:0] be, input logic v, input logic d,
                          input logic [19:0] tag, input logic [31:0] w);
    bus.port0_index_i      = idx;
    bus.port0_word_sel_i   = sel;
    bus.port0_enable_i     = data_cache_enable_t'(en);
    bus.port0_byte_write_i = be;
    bus.port0_valid_i      = v;
    bus.port0_dirty_i      = d;
    bus.port0_tag_i        = tag;
    bus.port0_word_i       = w;
    bus.port0_write_i      = 1'b1;
    tick();
    bus.port0_write_i      = 1'b0;
  endtask

  task automatic p1_read(input logic [5:0] idx, input logic [1:0] sel);
    bus.port1_index_i    = idx;
    bus.port1_word_sel_i = sel;
    bus.port1_read_i     = 1'b1;
    tick();
    bus.port1_read_i     = 1'b0;
  endtask

  task automatic wait_sweep(output int cycles);
    cycles = 0;
    while (busy && cycles < 200) begin
      tick();
      cycles++;
    end
  endtask

  initial begin
    idle_bus();
    #12;
    check("reset_busy", 64'(busy), 64'd1);
    check("reset_p1_word", 64'(bus.port1_word_o), 64'h0);
    check("reset_p0_tag", 64'(bus.port0_tag_o), 64'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_sweep(n);
    check("init_sweep_len", 64'(n), 64'd64);

    p1_read(6'd0, 2'd0);
    check("set0_valid", 64'(bus.port1_valid_o), 64'd0);
    check("set0_dirty", 64'(bus.port1_dirty_o), 64'd0);
    p1_read(6'd63, 2'd0);
    check("set63_valid", 64'(bus.port1_valid_o), 64'd0);
    check("set63_dirty", 64'(bus.port1_dirty_o), 64'd0);

    // Byte-merged data write over an old word
    p0_write(6'd5, 2'd2, 4'b1111, 4'b1111, 1'b1, 1'b0, 20'h00ABC, 32'h11223344);
    p0_write(6'd5, 2'd2, 4'b0001, 4'b0011, 1'b0, 1'b0, 20'h0, 32'hAABBCCDD);
    p1_read(6'd5, 2'd2);
    check("merge_word", 64'(bus.port1_word_o), 64'h1122CCDD);
    check("merge_tag", 64'(bus.port1_tag_o), 64'h00ABC);
    check("merge_valid", 64'(bus.port1_valid_o), 64'd1);

    // Disabled way ignores the write
    enable_way = 1'b0;
    p0_write(6'd5, 2'd2, 4'b1111, 4'b1111, 1'b0, 1'b1, 20'h55555, 32'hDEADBEEF);
    enable_way = 1'b1;
    p1_read(6'd5, 2'd2);
    check("noway_word", 64'(bus.port1_word_o), 64'h1122CCDD);
    check("noway_tag", 64'(bus.port1_tag_o), 64'h00ABC);
    check("noway_valid", 64'(bus.port1_valid_o), 64'd1);

    // Port 0 read-first on a same-cycle write
    bus.port0_read_i = 1'b1;
    p0_write(6'd5, 2'd2, 4'b1110, 4'b0000, 1'b1, 1'b1, 20'h00777, 32'h0);
    bus.port0_read_i = 1'b0;
    check("p0_rf_tag", 64'(bus.port0_tag_o), 64'h00ABC);
    check("p0_rf_dirty", 64'(bus.port0_dirty_o), 64'd0);
    bus.port0_enable_i = data_cache_enable_t'(4'b1110);
    bus.port0_read_i = 1'b1;
    tick();
    bus.port0_read_i = 1'b0;
    check("p0_new_tag", 64'(bus.port0_tag_o), 64'h00777);
    check("p0_new_dirty", 64'(bus.port0_dirty_o), 64'd1);

    // Same-cycle write and port 1 read at index 7
    p0_write(6'd7, 2'd0, 4'b1010, 4'b0000, 1'b1, 1'b0, 20'h00111, 32'h0);
    bus.port1_index_i = 6'd7;
    bus.port1_read_i  = 1'b1;
    p0_write(6'd7, 2'd0, 4'b0010, 4'b0000, 1'b0, 1'b0, 20'h12345, 32'h0);
    bus.port1_read_i  = 1'b0;
`ifdef DATA_CACHE_WAY_FORWARD_EN
    check("collide_tag", 64'(bus.port1_tag_o), 64'h12345);
`else
    check("collide_tag", 64'(bus.port1_tag_o), 64'h00111);
`endif
    p1_read(6'd7, 2'd0);
    check("after_collide_tag", 64'(bus.port1_tag_o), 64'h12345);

    // Flush, a second flush ignored, writes dropped, status reads 0 mid-sweep
    p0_write(6'd9, 2'd0, 4'b1110, 4'b0000, 1'b1, 1'b1, 20'h00999, 32'h0);
    p0_write(6'd11, 2'd0, 4'b0010, 4'b0000, 1'b0, 1'b0, 20'h0AAAA, 32'h0);
    p1_read(6'd9, 2'd0);
    check("pre_flush_valid", 64'(bus.port1_valid_o), 64'd1);
    check("pre_flush_dirty", 64'(bus.port1_dirty_o), 64'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_busy_n", 64'(busy), 64'd0);
    tick();
    check("flush_busy_n1", 64'(busy), 64'd1);
    bus.port0_index_i  = 6'd11;
    bus.port0_enable_i = data_cache_enable_t'(4'b0010);
    bus.port0_tag_i    = 20'h0BBBB;
    bus.port1_index_i  = 6'd9;
    n = 1;
    while (n < 200) begin
      flush             = (n == 9);
      bus.port0_write_i = (n == 20);
      bus.port1_read_i  = (n == 29);
      tick();
      if (n == 29) begin
        check("busy_read_valid", 64'(bus.port1_valid_o), 64'd0);
        check("busy_read_dirty", 64'(bus.port1_dirty_o), 64'd0);
      end
      if (!busy) break;
      n++;
    end
    flush             = 1'b0;
    bus.port0_write_i = 1'b0;
    bus.port1_read_i  = 1'b0;
    check("flush_sweep_len", 64'(n), 64'd64);
    p1_read(6'd9, 2'd0);
    check("swept_valid", 64'(bus.port1_valid_o), 64'd0);
    check("swept_dirty", 64'(bus.port1_dirty_o), 64'd0);
    check("swept_tag_kept", 64'(bus.port1_tag_o), 64'h00999);
    p1_read(6'd11, 2'd0);
    check("busy_write_dropped", 64'(bus.port1_tag_o), 64'h0AAAA);

    // Reset in cycle 30 of a sweep
    bus.port0_index_i  = 6'd5;
    bus.port0_enable_i = data_cache_enable_t'(4'b0010);
    bus.port0_read_i   = 1'b1;
    tick();
    bus.port0_read_i   = 1'b0;
    check("pre_rst_p0_tag", 64'(bus.port0_tag_o), 64'h00777);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    repeat (29) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 64'(busy), 64'd1);
    check("midrst_p0_tag", 64'(bus.port0_tag_o), 64'h0);
    check("midrst_p1_tag", 64'(bus.port1_tag_o), 64'h0);
    check("midrst_p1_valid", 64'(bus.port1_valid_o), 64'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_sweep(n);
    check("midrst_sweep_len", 64'(n), 64'd64);
    p1_read(6'd5, 2'd2);
    check("data_kept_word", 64'(bus.port1_word_o), 64'h1122CCDD);
    check("data_kept_valid", 64'(bus.port1_valid_o), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
